// File: rtl/atm_arb_pkg.sv
// Shared types and timing constants for the ATM kiosk arbiter.
package atm_arb_pkg;

  // One-hot session states
  typedef enum logic [2:0] {
    StIdle    = 3'b001,
    StSession = 3'b010,
    StRelease = 3'b100
  } arb_state_e;

  // Cycles the core is held with receivedCard low between sessions
  localparam int unsigned RELEASE_CYCLES = 2;

  // Session cycles during which stale core status flags are ignored
  localparam int unsigned SETTLE_CYCLES = 2;

endpackage

// File: rtl/rr_picker.sv
// Round-robin search: first eligible kiosk strictly after `last`, wrapping.
module rr_picker #(
  parameter int unsigned N_KIOSKS = 4,
  parameter int unsigned IdxW     = 2
) (
  input  logic [N_KIOSKS-1:0] eligible_i,
  input  logic [IdxW-1:0]     last_i,
  output logic                valid_o,
  output logic [IdxW-1:0]     winner_o
);

  // Walk from the farthest candidate to the nearest so the nearest one wins
  always_comb begin
    logic [IdxW-1:0] idx;
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int off = int'(N_KIOSKS); off >= 1; off--) begin
      idx = IdxW'((int'(last_i) + off) % int'(N_KIOSKS));
      if (eligible_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/atm_kiosk_arbiter.sv
// Shares one ATM transaction core among several kiosks, one session at a time.
module atm_kiosk_arbiter
  import atm_arb_pkg::*;
#(
  parameter int unsigned N_KIOSKS = 4,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned AMOUNT_W = 32
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic [N_KIOSKS-1:0]          kiosk_req_i,
  input  logic [4*N_KIOSKS-1:0]        kiosk_digit_i,
  input  logic [N_KIOSKS-1:0]          kiosk_stb_digit_i,
  input  logic [N_KIOSKS-1:0]          kiosk_trans_type_i,
  input  logic [N_KIOSKS-1:0]          kiosk_stb_trans_i,
  input  logic [N_KIOSKS-1:0]          kiosk_stb_amount_i,
  input  logic [AMOUNT_W*N_KIOSKS-1:0] kiosk_amount_i,
  input  logic                         core_balance_updated_i,
  input  logic                         core_insufficient_funds_i,
  input  logic                         core_block_i,
  output logic                         core_received_card_o,
  output logic [3:0]                   core_digit_o,
  output logic                         core_stb_digit_o,
  output logic                         core_trans_type_o,
  output logic                         core_stb_transaction_o,
  output logic                         core_stb_amount_o,
  output logic [AMOUNT_W-1:0]          core_amount_o,
  output logic [N_KIOSKS-1:0]          grant_o,
  output logic [N_KIOSKS-1:0]          done_o,
  output logic [N_KIOSKS-1:0]          timed_out_o
);

  localparam int unsigned IdxW = $clog2(N_KIOSKS);
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned RelW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  localparam logic [CntW-1:0] IdleMax   = CntW'(TIMEOUT - 1);
  localparam logic [SetW-1:0] SettleMax = SetW'(SETTLE_CYCLES);
  localparam logic [RelW-1:0] RelLast   = RelW'(RELEASE_CYCLES - 1);
  localparam logic [IdxW-1:0] LastInit  = IdxW'(N_KIOSKS - 1);

  arb_state_e state_q, state_d;

  logic [N_KIOSKS-1:0] grant_q, grant_d;
  logic [N_KIOSKS-1:0] lock_q, lock_d;
  logic [N_KIOSKS-1:0] done_q, done_d;
  logic [N_KIOSKS-1:0] timed_out_q, timed_out_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [CntW-1:0]     idle_q, idle_d;
  logic [SetW-1:0]     settle_q, settle_d;
  logic [RelW-1:0]     rel_q, rel_d;

  logic [N_KIOSKS-1:0] eligible;
  logic                pick_valid;
  logic [IdxW-1:0]     pick_idx;
  logic                in_session;
  logic                granted_stb;
  logic                core_flag;

  assign eligible    = kiosk_req_i & ~lock_q;
  assign in_session  = (state_q == StSession);
  assign core_flag   = core_balance_updated_i | core_insufficient_funds_i | core_block_i;
  assign granted_stb = core_stb_digit_o | core_stb_transaction_o | core_stb_amount_o;

  rr_picker #(
    .N_KIOSKS (N_KIOSKS),
    .IdxW     (IdxW)
  ) u_rr_picker (
    .eligible_i (eligible),
    .last_i     (last_q),
    .valid_o    (pick_valid),
    .winner_o   (pick_idx)
  );

  // Route the granted kiosk to the core; everything is zero outside a session
  always_comb begin
    core_digit_o           = '0;
    core_stb_digit_o       = 1'b0;
    core_trans_type_o      = 1'b0;
    core_stb_transaction_o = 1'b0;
    core_stb_amount_o      = 1'b0;
    core_amount_o          = '0;
    if (in_session) begin
      for (int i = 0; i < int'(N_KIOSKS); i++) begin
        if (grant_q[i]) begin
          core_digit_o           = kiosk_digit_i[4*i +: 4];
          core_stb_digit_o       = kiosk_stb_digit_i[i];
          core_trans_type_o      = kiosk_trans_type_i[i];
          core_stb_transaction_o = kiosk_stb_trans_i[i];
          core_stb_amount_o      = kiosk_stb_amount_i[i];
          core_amount_o          = kiosk_amount_i[AMOUNT_W*i +: AMOUNT_W];
        end
      end
    end
  end

  assign core_received_card_o = in_session;
  assign grant_o              = grant_q;
  assign done_o               = done_q;
  assign timed_out_o          = timed_out_q;

  // Next-state: grant selection, session exit checks and release countdown
  always_comb begin
    logic session_end;
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    idle_d      = idle_q;
    settle_d    = settle_q;
    rel_d       = rel_q;
    done_d      = '0;
    timed_out_d = '0;
    session_end = 1'b0;
    // A lock is forgotten once the card has been seen absent for a cycle
    lock_d      = lock_q & kiosk_req_i;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          last_d            = pick_idx;
          idle_d            = '0;
          settle_d          = '0;
          state_d           = StSession;
        end
      end

      StSession: begin
        if (granted_stb) begin
          idle_d = '0;
        end else if (idle_q != IdleMax) begin
          idle_d = idle_q + CntW'(1);
        end
        if (settle_q != SettleMax) begin
          settle_d = settle_q + SetW'(1);
        end

        // Card removal beats completion, which beats timeout
        if (!kiosk_req_i[last_q]) begin
          session_end = 1'b1;
        end else if (core_flag && (settle_q == SettleMax)) begin
          session_end     = 1'b1;
          done_d[last_q]  = 1'b1;
        end else if (idle_q == IdleMax) begin
          session_end          = 1'b1;
          timed_out_d[last_q]  = 1'b1;
        end

        if (session_end) begin
          grant_d        = '0;
          lock_d[last_q] = 1'b1;
          rel_d          = '0;
          state_d        = StRelease;
        end
      end

      StRelease: begin
        if (rel_q == RelLast) begin
          state_d = StIdle;
        end else begin
          rel_d = rel_q + RelW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // State and bookkeeping registers with synchronous reset
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      lock_q      <= '0;
      done_q      <= '0;
      timed_out_q <= '0;
      last_q      <= LastInit;
      idle_q      <= '0;
      settle_q    <= '0;
      rel_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lock_q      <= lock_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
      last_q      <= last_d;
      idle_q      <= idle_d;
      settle_q    <= settle_d;
      rel_q       <= rel_d;
    end
  end

endmodule

// File: tb/tb_atm_kiosk_arbiter.sv
// Directed bench for atm_kiosk_arbiter with a cycle-level reference model.
module tb_atm_kiosk_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int TMO = 20;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, kstbd, ktype, kstbt, kstba;
  logic [4*N-1:0]  kdig;
  logic [AW*N-1:0] kamt;
  logic            bal, ins, blk;

  logic            card;
  logic [3:0]      cdig;
  logic            cstbd, ctype, cstbt, cstba;
  logic [AW-1:0]   camt;
  logic [N-1:0]    grant, done, tmo;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  atm_kiosk_arbiter #(
    .N_KIOSKS (N),
    .TIMEOUT  (TMO),
    .AMOUNT_W (AW)
  ) dut (
    .clock_i                   (clk),
    .reset_i                   (rst),
    .kiosk_req_i               (req),
    .kiosk_digit_i             (kdig),
    .kiosk_stb_digit_i         (kstbd),
    .kiosk_trans_type_i        (ktype),
    .kiosk_stb_trans_i         (kstbt),
    .kiosk_stb_amount_i        (kstba),
    .kiosk_amount_i            (kamt),
    .core_balance_updated_i    (bal),
    .core_insufficient_funds_i (ins),
    .core_block_i              (blk),
    .core_received_card_o      (card),
    .core_digit_o              (cdig),
    .core_stb_digit_o          (cstbd),
    .core_trans_type_o         (ctype),
    .core_stb_transaction_o    (cstbt),
    .core_stb_amount_o         (cstba),
    .core_amount_o             (camt),
    .grant_o                   (grant),
    .done_o                    (done),
    .timed_out_o               (tmo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Steps until some kiosk owns the core; idx is -1 if none within budget
  task automatic wait_grant(output int idx);
    idx = -1;
    for (int b = 0; b < 20; b++) begin
      step();
      peek();
      if (grant != '0) begin
        for (int i = 0; i < N; i++) if (grant[i]) idx = i;
        break;
      end
    end
  endtask

  task automatic wait_release();
    bit ok;
    ok = 1'b0;
    for (int b = 0; b < 40; b++) begin
      step();
      peek();
      if (grant == '0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("release_budget", 64'(ok), 64'd1);
  endtask

  // Reference model: who owns the core, how long, and what must be visible
  initial begin : model
    int owner, phase, sess, quiet, rel, last, pdone, pto, cyc;
    bit [N-1:0] lock;
    logic [N-1:0] eg, ed, et;
    logic ec;
    logic [39:0] eroute, aroute;
    bit found, ending, stb, flag;
    owner = -1; phase = 0; sess = 0; quiet = 0; rel = 0;
    last = N - 1; pdone = -1; pto = -1; lock = '0; cyc = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      eg = '0; ed = '0; et = '0; ec = 1'b0; eroute = '0;
      if (owner >= 0) begin
        eg[owner] = 1'b1;
        ec = 1'b1;
        eroute = {kdig[4*owner +: 4], kstbd[owner], ktype[owner], kstbt[owner],
                  kstba[owner], kamt[AW*owner +: AW]};
      end
      if (pdone >= 0) ed[pdone] = 1'b1;
      if (pto >= 0) et[pto] = 1'b1;
      aroute = {cdig, cstbd, ctype, cstbt, cstba, camt};
      vectors++;
      if ({grant, done, tmo, card} !== {eg, ed, et, ec} || aroute !== eroute) begin
        miscompares++;
        $display("FAIL cycle %0d: grant=%b/%b done=%b/%b timed_out=%b/%b card=%b/%b route=%h/%h (got/exp)",
                 cyc, grant, eg, done, ed, tmo, et, card, ec, aroute, eroute);
      end

      // Advance to the state after the coming clock edge
      if (rst) begin
        owner = -1; phase = 0; sess = 0; quiet = 0; rel = 0;
        last = N - 1; pdone = -1; pto = -1; lock = '0;
      end else begin
        pdone = -1;
        pto   = -1;
        for (int i = 0; i < N; i++) if (!req[i]) lock[i] = 1'b0;
        if (phase == 0) begin
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (!found && req[j] && !lock[j]) begin
              found = 1'b1; owner = j; last = j; phase = 1; sess = 0; quiet = 0;
            end
          end
        end else if (phase == 1) begin
          stb    = kstbd[owner] | kstbt[owner] | kstba[owner];
          flag   = bal | ins | blk;
          ending = 1'b1;
          if (!req[owner]) ;
          else if (sess >= 2 && flag) pdone = owner;
          else if (quiet == TMO - 1) pto = owner;
          else ending = 1'b0;
          if (stb) quiet = 0;
          else if (quiet < TMO - 1) quiet++;
          sess++;
          if (ending) begin
            lock[owner] = 1'b1; owner = -1; phase = 2; rel = 2;
          end
        end else begin
          rel--;
          if (rel == 0) phase = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    int idx;
    rst = 1'b1; req = '0; kstbd = '0; ktype = '0; kstbt = '0; kstba = '0;
    kdig = '0; kamt = '0; bal = 1'b0; ins = 1'b0; blk = 1'b0;
    repeat (3) step();
    peek();
    chk("reset_grant", 64'(grant), 64'd0);
    chk("reset_card", 64'(card), 64'd0);
    chk("reset_done", 64'(done), 64'd0);

    // Kiosks 0 and 2 together: 0 wins, completes, then 2 after the gap
    step(); rst = 1'b0; req = 4'b0101;
    peek(); chk("t1_not_yet", 64'(grant), 64'd0);
    wait_grant(idx); chk("t1_first", 64'(idx), 64'd0);
    step(); bal = 1'b1;
    step(); peek(); chk("t1_settle_hold", 64'(grant), 64'b0001);
    step(); bal = 1'b0; peek();
    chk("t1_done", 64'(done), 64'b0001);
    chk("t1_rel_card", 64'(card), 64'd0);
    step(); peek(); chk("t1_done_once", 64'(done), 64'd0);
    step(); peek(); chk("t1_idle_gap", 64'(grant), 64'd0);
    step(); peek(); chk("t1_next", 64'(grant), 64'b0100);

    // Removal and completion collide: removal wins, no done
    step();
    step(); req[2] = 1'b0; bal = 1'b1;
    step(); bal = 1'b0; req[0] = 1'b0; peek();
    chk("t2_no_done", 64'(done), 64'd0);
    chk("t2_rel", 64'(grant), 64'd0);
    step(); step(); step(); peek(); chk("t2_quiet", 64'(grant), 64'd0);

    // Isolation and routing with kiosk 1 granted
    step(); req = 4'b0010;
    wait_grant(idx); chk("t3_k1", 64'(idx), 64'd1);
    step(); req[3] = 1'b1; kdig[15:12] = 4'd7; kstbd[3] = 1'b1; peek();
    chk("t3_iso_stb", 64'(cstbd), 64'd0);
    chk("t3_iso_digit", 64'(cdig), 64'd0);
    step(); kstbd[3] = 1'b0; kdig[7:4] = 4'd5; kstbd[1] = 1'b1; peek();
    chk("t3_route_stb", 64'(cstbd), 64'd1);
    chk("t3_route_digit", 64'(cdig), 64'd5);
    step(); kstbd[1] = 1'b0; kamt[63:32] = 32'hCAFE_0042; ktype[1] = 1'b1; kstba[1] = 1'b1;
    peek();
    chk("t3_amount", 64'(camt), 64'hCAFE_0042);
    chk("t3_type", 64'(ctype), 64'd1);
    step(); kstba[1] = 1'b0; ktype[1] = 1'b0; req[1] = 1'b0;

    // Kiosk 3 idles out: timed_out after 20 silent session cycles
    wait_grant(idx); chk("t4_k3", 64'(idx), 64'd3);
    repeat (19) step();
    peek();
    chk("t4_pre_pulse", 64'(tmo), 64'd0);
    chk("t4_pre_grant", 64'(grant), 64'b1000);
    step(); peek();
    chk("t4_pulse", 64'(tmo), 64'b1000);
    chk("t4_card_lo1", 64'(card), 64'd0);
    step(); peek();
    chk("t4_card_lo2", 64'(card), 64'd0);
    chk("t4_pulse_once", 64'(tmo), 64'd0);
    step(); step(); step(); peek(); chk("t4_locked", 64'(grant), 64'd0);
    step(); req[3] = 1'b0;

    // Fairness with everyone requesting; locks block re-grant
    step(); req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_grant(idx); chk($sformatf("fair_order%0d", k), 64'(idx), 64'(k));
      step(); ins = 1'b1;
      wait_release();
      step(); ins = 1'b0;
    end
    repeat (5) step();
    peek(); chk("fair_locked", 64'(grant), 64'd0);
    step(); req[0] = 1'b0;
    step(); req[0] = 1'b1;
    wait_grant(idx); chk("fair_wrap", 64'(idx), 64'd0);

    // Reset mid-session
    step(); rst = 1'b1;
    step(); rst = 1'b0; peek();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_card", 64'(card), 64'd0);
    step(); peek(); chk("rst_k0_wins", 64'(grant), 64'b0001);

    step(); req = '0;
    repeat (5) step();
    peek();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
